// File: rtl/ccc_cfg_pkg.sv
// Shared definitions for the CCC dynamic-reconfiguration APB initiator:
// FSM state encoding, APB widths and CCC register map.
package ccc_cfg_pkg;

  localparam int APB_AW = 6;
  localparam int APB_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_LOCK,
    RESP
  } ccc_state_e;

  localparam logic [APB_AW-1:0] CCC_REG_PLL_STAT = 6'h05;
  localparam logic [APB_AW-1:0] CCC_REG_PLL_CFG  = 6'h10;
  localparam logic [APB_AW-1:0] CCC_REG_PLL_DIV  = 6'h11;
  localparam logic [APB_AW-1:0] CCC_REG_OUT_CFG  = 6'h22;

endpackage

// File: rtl/ccc_sync_bit.sv
// Single-bit synchronizer: STAGES-deep flop chain, asynchronously cleared to 0.
module ccc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ccc_apb_reconfig.sv
// APB initiator that turns single user requests into CCC dynamic-configuration
// accesses. Define CCC_LOCK_WAIT_EN to make writes wait for PLL LOCK (with timeout).
module ccc_apb_reconfig
  import ccc_cfg_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 4095,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [APB_AW-1:0] req_addr,
  input  logic [APB_DW-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_AW-1:0] PADDR,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              LOCK,
  input  logic              BUSY
);

  ccc_state_e state, state_nxt;
  logic       busy_s;
  logic       ready_en;
  logic       accept;

  ccc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_busy (
    .clk   (PCLK),
    .rst_n (PRESET_N),
    .d     (BUSY),
    .q     (busy_s)
  );

  // A constant 1 shifted through a synchronizer keeps req_ready low for
  // SYNC_STAGES cycles after reset release.
  ccc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk   (PCLK),
    .rst_n (PRESET_N),
    .d     (1'b1),
    .q     (ready_en)
  );

  assign req_ready = (state == IDLE) && ready_en && !busy_s;
  assign accept    = req_valid && req_ready;
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

`ifdef CCC_LOCK_WAIT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic             lock_s;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_timeout;

  ccc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (PCLK),
    .rst_n (PRESET_N),
    .d     (LOCK),
    .q     (lock_s)
  );

  // Timeout fires on the cycle whose increment brings the count to LOCK_TIMEOUT.
  assign lock_timeout = (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      lock_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == WAIT_LOCK) begin
        if (lock_cnt != CNT_W'(LOCK_TIMEOUT)) begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end else begin
        lock_cnt <= '0;
      end
      if (state == ACCESS) begin
        rsp_err <= 1'b0;
      end else if ((state == WAIT_LOCK) && !lock_s && lock_timeout) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = LOCK ^ (LOCK_TIMEOUT == 0);
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
`ifdef CCC_LOCK_WAIT_EN
      ACCESS: state_nxt = PWRITE ? WAIT_LOCK : RESP;
      WAIT_LOCK: if (lock_s || lock_timeout) state_nxt = RESP;
`else
      ACCESS: state_nxt = RESP;
`endif
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields drive the APB bus directly and hold between transfers.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
      if (state == ACCESS) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end
    end
  end

endmodule

// File: doc/ccc_apb_reconfig.md
CCC_APB_RECONFIG -- requirements
Module: ccc_apb_reconfig

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 4095, meaning max PCLK cycles to wait for LOCK after a write.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flop count of the LOCK/BUSY synchronizers (legal 2..4).
REQ-003 SHALL have port PCLK  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port PRESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  user request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have ports req_write input 1, req_addr input 6, req_wdata input 8: direction, CCC register address, write data.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_rdata output 8, rsp_err output 1: completion handshake, read data, lock-timeout flag.
REQ-009 SHALL have APB initiator ports PSEL, PENABLE, PWRITE output 1 each, PADDR output 6, PWDATA output 8, PRDATA input 8, driving the CCC dynamic-configuration port.
REQ-010 SHALL have inputs LOCK 1 (CCC PLL lock) and BUSY 1 (CCC busy), both asynchronous to PCLK.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, WAIT_LOCK, RESP.
REQ-012 IDLE: req_ready = 1 only when synchronized BUSY = 0; accept on req_valid & req_ready, latch addr/wdata/write, go SETUP.
REQ-013 SETUP: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE from latched request; exactly one cycle, go ACCESS.
REQ-014 ACCESS: PSEL=1, PENABLE=1, exactly one cycle (no PREADY); reads capture PRDATA at end of ACCESS into rsp_rdata.
REQ-015 After ACCESS: read -> RESP; write -> WAIT_LOCK when CCC_LOCK_WAIT_EN defined, else RESP.
REQ-016 WAIT_LOCK: timeout counter starts at 0 on entry, increments per cycle; synchronized LOCK = 1 -> RESP with rsp_err=0; counter reaching LOCK_TIMEOUT -> RESP with rsp_err=1; LOCK and timeout in same cycle -> rsp_err=0.
REQ-017 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid & rsp_ready, then IDLE; rsp_ready held high gives one-cycle RESP.
REQ-018 Minimum request-to-rsp_valid latency for a read: 3 cycles (accept, SETUP, ACCESS, rsp_valid in next).
REQ-019 PSEL/PENABLE SHALL be 0 in IDLE, WAIT_LOCK, RESP; PADDR/PWDATA hold last value outside transfers.
REQ-020 rsp_rdata SHALL be 8'h00 after a write completion.
REQ-021 Timeout counter width SHALL be $clog2(LOCK_TIMEOUT+1); no wrap.
REQ-022 BUSY rising during SETUP/ACCESS/WAIT_LOCK SHALL NOT abort the transfer.

Reset
REQ-023 PRESET_N low SHALL asynchronously force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, synchronizers=0.
REQ-024 Reset mid-transfer SHALL drop PSEL/PENABLE immediately; no response is issued for the aborted request.
REQ-025 req_ready SHALL be 0 during reset and for SYNC_STAGES cycles after release.

Configuration
REQ-026 Macro CCC_LOCK_WAIT_EN defined: WAIT_LOCK state, timeout counter, LOCK synchronizer compiled in; writes complete per REQ-016.
REQ-027 CCC_LOCK_WAIT_EN undefined: no WAIT_LOCK logic; LOCK input unused; rsp_err tied 0; writes go ACCESS -> RESP.

Structure
REQ-028 Shared package ccc_cfg_pkg SHALL hold the FSM state enum, APB address/data width constants (6, 8), and CCC register address constants.
REQ-029 Sub-module ccc_sync_bit (SYNC_STAGES-deep, async-reset-to-0 flop chain) SHALL be instantiated for LOCK and BUSY.

Verification
REQ-030 Read addr 6'h05, PRDATA=8'hA5 -> one SETUP, one ACCESS with PWRITE=0, rsp_rdata=8'hA5, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-031 Write addr 6'h10 data 8'h3C, LOCK rises 20 cycles after ACCESS (WAIT_EN) -> PWDATA=8'h3C in ACCESS, rsp_valid ~20+SYNC_STAGES cycles later, rsp_err=0.
REQ-032 Write with LOCK held 0, LOCK_TIMEOUT=15 -> rsp_valid after 15 WAIT_LOCK cycles, rsp_err=1.
REQ-033 BUSY=1 with req_valid=1 for 10 cycles -> req_ready=0, PSEL=0 throughout; accept SYNC_STAGES cycles after BUSY falls.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, no new request accepted.
REQ-035 PRESET_N asserted during ACCESS -> PSEL=PENABLE=0 same cycle, no rsp_valid after release.
